// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
// master drives requests; slave (dmem_ctrl) answers with ready/response/busy.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, is_load, is_store, funct3, addr, w_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, is_load, is_store, funct3, addr, w_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory responder: word RAM with byte/half/word access and load extension; MISALIGN_TRAP_EN enables misalignment trapping.
// Latency: accept edge E0 -> rsp_valid pulse in the cycle after edge E0+LATENCY+1.
// Backpressure: req_ready (= !busy) only in IDLE; one access in flight, issue period LATENCY+3.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   wdat_q, wdat_d;
    logic          store_q, store_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          fire;
    logic          is_byte, is_half;
    logic          misalign;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_val;
    logic [3:0]    be;
    logic [31:0]   wr_lanes;
    logic          we;

    assign fire    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign is_byte = (f3_q[1:0] == 2'b00);
    assign is_half = (f3_q[1:0] == 2'b01);
    assign idx     = addr_q[AW+1:2];

`ifdef MISALIGN_TRAP_EN
    assign misalign = (is_half && addr_q[0]) || (!is_byte && !is_half && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Load path: read the addressed word, then pick and extend the lane.
    always_comb begin
        rd_word = mem[idx];
        rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        ld_val  = rd_word;
        if (is_byte) begin
            ld_val = f3_q[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        end else if (is_half) begin
            ld_val = f3_q[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
        end
    end

    always_comb begin
        be       = 4'b1111;
        wr_lanes = wdat_q;
        if (is_byte) begin
            be       = 4'b0001 << addr_q[1:0];
            wr_lanes = {4{wdat_q[7:0]}};
        end else if (is_half) begin
            be       = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{wdat_q[15:0]}};
        end
    end

    assign we = fire && store_q && !misalign;

    // RAM is deliberately left unreset; state_q is IDLE during reset so no write can slip in.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdat_d  = wdat_q;
        store_d = store_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && (bus.is_load || bus.is_store)) begin
                    addr_d  = bus.addr[AW+1:0];
                    f3_d    = bus.funct3;
                    wdat_d  = bus.w_data;
                    store_d = bus.is_store && !bus.is_load;
                    cnt_d   = 4'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = (store_q || misalign) ? 32'd0 : ld_val;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            wdat_q  <= 32'd0;
            store_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdat_q  <= wdat_d;
            store_q <= store_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    err_q <= 1'b0;
        else if (fire) err_q <= misalign;
    end
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a byte-array reference model predicts each response,
// a separate monitor pops and compares on rsp_valid.
module tb_dmem_ctrl;
    localparam int LAT   = 2;
    localparam int DEPTH = 4096;
    localparam int NBYTE = DEPTH * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    dmem_ctrl_if bus();

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem_m [NBYTE];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: flat byte memory, size and extension taken straight from funct3.
    function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] d, output logic e);
        int sz;
        int off;
        int base;
        logic [31:0] v;
        sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(a % NBYTE);
        base = (off / sz) * sz;
        d = 32'd0;
        e = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (off % sz != 0) e = 1'b1;
`endif
        if (e) return;
        if (!ld && st) begin
            for (int i = 0; i < sz; i++) mem_m[base + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v = v | (32'(mem_m[base + i]) << (8 * i));
            if (!f3[2] && sz == 1 && v[7])  v = v - 32'd256;
            if (!f3[2] && sz == 2 && v[15]) v = v - 32'd65536;
            d = v;
        end
    endfunction

    task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t x;
        int   low;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.is_load   = ld;
        bus.is_store  = st;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.w_data    = wd;
        @(posedge clk);
        #1;
        model(ld, st, f3, a, wd, x.d, x.e);
        x.cyc = cyc;
        exp_q.push_back(x);
        bus.req_valid = 1'b0;
        bus.is_load   = 1'($urandom);
        bus.is_store  = 1'($urandom);
        bus.funct3    = 3'($urandom);
        bus.addr      = $urandom;
        bus.w_data    = $urandom;
        low = 0;
        while (1) begin
            @(negedge clk);
            chk("busy_vs_ready", 32'(bus.busy), 32'(!bus.req_ready));
            if (bus.req_ready) break;
            low++;
            if (low > 50) begin
                checks++; errors++;
                $display("FAIL ready_timeout: req_ready still low after %0d cycles", low);
                break;
            end
        end
        chk("ready_low_cycles", 32'(low), 32'(LAT + 2));
    endtask

    // Monitor: every response must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding, data 0x%08h", bus.rsp_data);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("rsp_data", bus.rsp_data, x.d);
                chk("rsp_err", 32'(bus.rsp_err), 32'(x.e));
                chk("rsp_latency", 32'(cyc - x.cyc), 32'(LAT + 1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.is_load   = 1'b0;
        bus.is_store  = 1'b0;
        bus.funct3    = 3'd0;
        bus.addr      = 32'd0;
        bus.w_data    = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data", bus.rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        rst_n = 1'b1;

        // Word round trip, then reset mid-WAIT of a store.
        do_req(0, 1, 3'b010, 32'h10, 32'h0);
        do_req(0, 1, 3'b010, 32'h40, 32'hDEADBEEF);
        do_req(1, 0, 3'b010, 32'h40, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.is_load = 1'b0; bus.is_store = 1'b1;
        bus.funct3 = 3'b010; bus.addr = 32'h10; bus.w_data = 32'h11223344;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_rsp_data", bus.rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1, 0, 3'b010, 32'h10, 32'h0);

        // Byte and half extension.
        do_req(0, 1, 3'b000, 32'h41, 32'h80);
        do_req(1, 0, 3'b000, 32'h41, 32'h0);
        do_req(1, 0, 3'b100, 32'h41, 32'h0);
        do_req(1, 0, 3'b010, 32'h40, 32'h0);
        do_req(0, 1, 3'b001, 32'h42, 32'h8001);
        do_req(1, 0, 3'b001, 32'h42, 32'h0);
        do_req(1, 0, 3'b101, 32'h42, 32'h0);

        // Both flags -> load; address wrap-around.
        do_req(1, 1, 3'b010, 32'h40, 32'h12345678);
        do_req(1, 0, 3'b010, 32'h40, 32'h0);
        do_req(0, 1, 3'b010, 32'h4000, 32'h5);
        do_req(1, 0, 3'b010, 32'h0, 32'h0);

        // Misaligned word store.
        do_req(0, 1, 3'b010, 32'h80, 32'h0);
        do_req(0, 1, 3'b010, 32'h82, 32'hCAFEF00D);
        do_req(1, 0, 3'b010, 32'h80, 32'h0);

        // Request with neither flag set is ignored.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.is_load = 1'b0; bus.is_store = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("ignored_req_ready", 32'(bus.req_ready), 32'd1);

        // Randomized traffic over a pre-initialized window, with aliased upper bits.
        for (int i = 0; i < 16; i++) do_req(0, 1, 3'b010, 32'h100 + 32'(4 * i), $urandom);
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            int          op;
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 14);
            op = $urandom_range(0, 2);
            do_req(op != 1, op != 0, f3, a, $urandom);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
